seg_scan_decoder: RTL
=====================

// Module: seg_scan_decoder
// PURPOSE
//  Receive end of the 8-digit multiplexed 7-segment scan bus (seg_which one-hot digit select + seg_data segments).
//  Samples the scan, waits for each digit to settle, decodes segment patterns back to 4-bit digit codes, and assembles a full 8-digit frame.
//  Used on-chip as a display self-check/readback monitor beside the clock/stopwatch display driver.
// PARAMETERS
//  STABLE_CYC  16  consecutive identical samples of {seg_which,seg_data} required before a digit is captured (>=2)
//  CNT_W       8   settle-counter width; must hold STABLE_CYC
// PORTS
//  clk          in   1   system clock, 100 MHz
//  rst          in   1   asynchronous, active-low reset
//  seg_which    in   8   digit select, one-hot; bit7 = position 0 (leftmost) ... bit0 = position 7
//  seg_data     in   8   segments {a,b,c,d,e,f,g,dp}, active-high
//  err_clr      in   1   clears code_err and scan_err (synchronous)
//  digits       out  32  last complete frame; [31:28]=pos0 ... [3:0]=pos7
//  blank_mask   out  8   bit7=pos0 ... bit0=pos7; 1 = position not captured in last frame
//  frame_valid  out  1   one-cycle pulse when digits/blank_mask update
//  code_err     out  1   sticky: an undecodable segment pattern was captured
//  scan_err     out  1   sticky: a non-zero, non-one-hot seg_which stayed stable STABLE_CYC cycles
// BEHAVIOUR
//  Reset: digits=32'h0, blank_mask=8'hFF, frame_valid=0, code_err=0, scan_err=0, FSM=IDLE, seen=0, last_idx=7, settle cnt=0.
//  Inputs registered once (s_which, s_data); all decisions use the registered copies.
//  Segment decode: FC->0 60->1 DA->2 F2->3 66->4 B6->5 BE->6 E0->7 FE->8 F6->9 02->4'hA (dash);
//    any other pattern -> 4'hF and sets code_err when captured.
//  FSM (states IDLE, SETTLE, HELD):
//   IDLE:   s_which==0 -> stay; else load cnt=1, go SETTLE.
//   SETTLE: sample differs from previous -> cnt=1 (stay SETTLE), or IDLE if s_which==0;
//           sample equal and cnt==STABLE_CYC-1 -> capture edge, go HELD; else cnt++.
//   HELD:   sample differs from captured -> IDLE if s_which==0, else cnt=1 and SETTLE; equal -> stay (no re-capture).
//  Capture edge (one-hot s_which, idx=7-bit position):
//   if seen!=0 and idx<=last_idx (scan wrapped): digits<=shadow, blank_mask<=~seen, frame_valid<=1, seen<=0 then mark idx;
//   shadow[idx]<=decoded code, seen[idx]<=1, last_idx<=idx.
//   Publish and new-frame store occur on the same edge; publish uses pre-edge shadow.
//  Non-one-hot stable s_which: no capture, scan_err<=1, FSM to HELD (waits for change).
//  Blanked digits (s_which==0 during blink) never capture; show as 1 in blank_mask for that frame.
//  Latency: digit captured STABLE_CYC+1 clk after input change (1 input reg + STABLE_CYC-1 count edges + capture);
//    frame published on capture of the first digit of the next frame.
//  One-cycle which/data skew from the driver is absorbed by the settle counter.
//  Only positions that wrap trigger publish; same position repeated after change (e.g. data changes mid-digit) publishes a frame.
//  err_clr and new error same cycle: error wins (flag stays 1).
//  Reset mid-frame discards shadow; first post-reset frame is published only after a wrap.
// STRUCTURE
//  Shared package: segment pattern constants SEG_0..SEG_9, SEG_DASH; digit codes CODE_DASH=4'hA, CODE_BAD=4'hF; FSM state encoding.
//  Sub-module seg7_to_code (combinational 8-bit pattern -> 4-bit code + bad flag), instanced once.
//  Top holds input regs, settle counter/FSM, shadow[8], seen, last_idx, output regs.
// TESTING
//  Scan 23-59-55 (FC? no: 2,3,-,5,9,-,5,5), 50 clk/digit, two passes -> frame_valid once, digits=32'h23A59A55, blank_mask=0.
//  Digit held only STABLE_CYC-1 cycles -> not captured; its blank_mask bit=1 at next publish.
//  Pos0/pos1 driven with seg_which=0 (blink) -> digits[31:24] keep shadow reset 0, blank_mask=8'hC0.
//  seg_data=8'h81 stable on pos3 -> digits[19:16]=4'hF, code_err=1 until err_clr pulse, then 0.
//  seg_which=8'h11 stable 20 clk -> scan_err=1, no capture; next valid scan still decodes correctly.
//  Assert rst low mid-frame -> all outputs to reset values asynchronously; next full scan+wrap publishes correct frame.

Source files
------------

// File: rtl/seg_scan_decoder_pkg.sv
// seg_scan_decoder_pkg: segment patterns, digit codes, FSM states and scan helpers
package seg_scan_decoder_pkg;
  localparam logic [7:0] SEG_0    = 8'hFC;
  localparam logic [7:0] SEG_1    = 8'h60;
  localparam logic [7:0] SEG_2    = 8'hDA;
  localparam logic [7:0] SEG_3    = 8'hF2;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'hB6;
  localparam logic [7:0] SEG_6    = 8'hBE;
  localparam logic [7:0] SEG_7    = 8'hE0;
  localparam logic [7:0] SEG_8    = 8'hFE;
  localparam logic [7:0] SEG_9    = 8'hF6;
  localparam logic [7:0] SEG_DASH = 8'h02;
  localparam logic [3:0] CODE_DASH = 4'hA;
  localparam logic [3:0] CODE_BAD  = 4'hF;
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
  // Bit 7 of the select is display position 0, so position = 7 - bit index.
  function automatic logic [2:0] which_pos(input logic [7:0] w);
    logic [2:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (w[i]) p = 3'(7 - i);
    return p;
  endfunction
  function automatic logic is_onehot(input logic [7:0] w);
    return (w != 8'h00) && ((w & (w - 8'd1)) == 8'h00);
  endfunction
endpackage

// File: rtl/seg_scan_decoder_seg7.sv
// seg7_to_code: maps an active-high {a..g,dp} pattern back to its digit code
module seg7_to_code
  import seg_scan_decoder_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] code,
  output logic       bad
);
  always_comb begin
    case (pattern)
      SEG_0:    code = 4'h0;
      SEG_1:    code = 4'h1;
      SEG_2:    code = 4'h2;
      SEG_3:    code = 4'h3;
      SEG_4:    code = 4'h4;
      SEG_5:    code = 4'h5;
      SEG_6:    code = 4'h6;
      SEG_7:    code = 4'h7;
      SEG_8:    code = 4'h8;
      SEG_9:    code = 4'h9;
      SEG_DASH: code = CODE_DASH;
      default:  code = CODE_BAD;
    endcase
  end
  assign bad = (code == CODE_BAD);
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 7-segment scan, waits for each digit to settle,
// decodes it and publishes a full 8-digit frame each time the scan wraps.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int STABLE_CYC = 16,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_which,
  input  logic [7:0]  seg_data,
  input  logic        err_clr,
  output logic [31:0] digits,
  output logic [7:0]  blank_mask,
  output logic        frame_valid,
  output logic        code_err,
  output logic        scan_err
);
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        s_which_q, s_which_d, s_data_q, s_data_d;
  logic [7:0]        p_which_q, p_which_d, p_data_q, p_data_d;
  logic [3:0]        shadow_q [8];
  logic [3:0]        shadow_d [8];
  logic [7:0]        seen_q, seen_d;
  logic [2:0]        last_idx_q, last_idx_d;
  logic [31:0]       digits_q, digits_d;
  logic [7:0]        blank_q, blank_d;
  logic              fv_q, fv_d, code_err_q, code_err_d, scan_err_q, scan_err_d;
  logic [3:0]        code;
  logic              bad, changed, capture;
  logic [2:0]        idx;

  seg7_to_code u_dec (.pattern(s_data_q), .code(code), .bad(bad));

  assign idx     = which_pos(s_which_q);
  assign changed = {s_which_q, s_data_q} != {p_which_q, p_data_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s_which_d  = seg_which;
    s_data_d   = seg_data;
    p_which_d  = s_which_q;
    p_data_d   = s_data_q;
    shadow_d   = shadow_q;
    seen_d     = seen_q;
    last_idx_d = last_idx_q;
    digits_d   = digits_q;
    blank_d    = blank_q;
    fv_d       = 1'b0;
    code_err_d = code_err_q & ~err_clr;
    scan_err_d = scan_err_q & ~err_clr;
    capture    = 1'b0;
    case (state_q)
      IDLE: if (s_which_q != 8'h00) begin
        cnt_d   = CNT_W'(1);
        state_d = SETTLE;
      end
      SETTLE: if (changed) begin
        cnt_d   = CNT_W'(1);
        state_d = (s_which_q == 8'h00) ? IDLE : SETTLE;
      end else if (cnt_q == CNT_W'(STABLE_CYC - 1)) begin
        capture = 1'b1;
        state_d = HELD;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      HELD: if (changed) begin
        cnt_d   = CNT_W'(1);
        state_d = (s_which_q == 8'h00) ? IDLE : SETTLE;
      end
      default: state_d = IDLE;
    endcase
    // A position at or left of the last captured one means the scan wrapped.
    if (capture && !is_onehot(s_which_q)) begin
      scan_err_d = 1'b1;
    end else if (capture) begin
      if (seen_q != 8'h00 && idx <= last_idx_q) begin
        for (int i = 0; i < 8; i++) digits_d[31-4*i -: 4] = shadow_q[i];
        blank_d = ~seen_q;
        fv_d    = 1'b1;
        seen_d  = s_which_q;
      end else begin
        seen_d = seen_q | s_which_q;
      end
      shadow_d[idx] = code;
      last_idx_d    = idx;
      code_err_d    = code_err_d | bad;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s_which_q  <= '0;
      s_data_q   <= '0;
      p_which_q  <= '0;
      p_data_q   <= '0;
      shadow_q   <= '{default: '0};
      seen_q     <= '0;
      last_idx_q <= 3'd7;
      digits_q   <= '0;
      blank_q    <= 8'hFF;
      fv_q       <= 1'b0;
      code_err_q <= 1'b0;
      scan_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_which_q  <= s_which_d;
      s_data_q   <= s_data_d;
      p_which_q  <= p_which_d;
      p_data_q   <= p_data_d;
      shadow_q   <= shadow_d;
      seen_q     <= seen_d;
      last_idx_q <= last_idx_d;
      digits_q   <= digits_d;
      blank_q    <= blank_d;
      fv_q       <= fv_d;
      code_err_q <= code_err_d;
      scan_err_q <= scan_err_d;
    end
  end

  assign digits      = digits_q;
  assign blank_mask  = blank_q;
  assign frame_valid = fv_q;
  assign code_err    = code_err_q;
  assign scan_err    = scan_err_q;
endmodule
